// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester handshakes, register-file write port and pending mask
interface regfile_write_arbiter_if #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic [4:0]            req0_reg;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [4:0]            req1_reg;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  ctrl_writeEnable;
  logic [4:0]            ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic                  grant_id;
  logic [NUM_REGS-1:0]   pending_mask;

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, pending_mask
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, pending_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write-port arbiter
// One-entry buffer per requester; oldest entry wins, round-robin on same-edge ties.
module regfile_write_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                    clock,
  input logic                    ctrl_reset,
  regfile_write_arbiter_if.slave bus
);
  logic                  buf0_full_q, buf0_full_d;
  logic [4:0]            buf0_reg_q, buf0_reg_d;
  logic [DATA_WIDTH-1:0] buf0_data_q, buf0_data_d;
  logic                  buf1_full_q, buf1_full_d;
  logic [4:0]            buf1_reg_q, buf1_reg_d;
  logic [DATA_WIDTH-1:0] buf1_data_q, buf1_data_d;
  logic                  old0_q, old0_d;
  logic                  tie_q, tie_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [4:0]            wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  gid_q, gid_d;

  logic                  pick0, grant0, grant1;
  logic                  ready0, ready1, load0, load1;
  logic [NUM_REGS-1:0]   pending;

  always_comb begin
    // On a same-edge tie the age flag is meaningless; the pointer decides.
    pick0  = tie_q ? last_grant_q : old0_q;
    grant0 = buf0_full_q & (~buf1_full_q | pick0);
    grant1 = buf1_full_q & ~grant0;
    ready0 = ctrl_reset & (~buf0_full_q | grant0);
    ready1 = ctrl_reset & (~buf1_full_q | grant1);
    load0  = bus.req0_valid & ready0 & (bus.req0_reg != 5'd0);
    load1  = bus.req1_valid & ready1 & (bus.req1_reg != 5'd0);
  end

  always_comb begin
    buf0_full_d  = buf0_full_q & ~grant0;
    buf0_reg_d   = buf0_reg_q;
    buf0_data_d  = buf0_data_q;
    buf1_full_d  = buf1_full_q & ~grant1;
    buf1_reg_d   = buf1_reg_q;
    buf1_data_d  = buf1_data_q;
    old0_d       = old0_q;
    tie_d        = tie_q;
    last_grant_d = last_grant_q;
    we_d         = grant0 | grant1;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    gid_d        = gid_q;

    if (load0) begin
      buf0_full_d = 1'b1;
      buf0_reg_d  = bus.req0_reg;
      buf0_data_d = bus.req0_data;
    end
    if (load1) begin
      buf1_full_d = 1'b1;
      buf1_reg_d  = bus.req1_reg;
      buf1_data_d = bus.req1_data;
    end

    // After this edge, whichever buffer was not just loaded is the older one.
    if (load0 && load1) begin
      tie_d  = 1'b1;
      old0_d = 1'b1;
    end else if (load0) begin
      tie_d  = 1'b0;
      old0_d = ~(buf1_full_q & ~grant1);
    end else if (load1) begin
      tie_d  = 1'b0;
      old0_d = buf0_full_q & ~grant0;
    end

    if (grant0 | grant1) begin
      wreg_d       = grant1 ? buf1_reg_q : buf0_reg_q;
      wdata_d      = grant1 ? buf1_data_q : buf0_data_q;
      gid_d        = grant1;
      last_grant_d = grant1;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      buf0_full_q  <= 1'b0;
      buf0_reg_q   <= 5'd0;
      buf0_data_q  <= '0;
      buf1_full_q  <= 1'b0;
      buf1_reg_q   <= 5'd0;
      buf1_data_q  <= '0;
      old0_q       <= 1'b0;
      tie_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      wreg_q       <= 5'd0;
      wdata_q      <= '0;
      gid_q        <= 1'b0;
    end else begin
      buf0_full_q  <= buf0_full_d;
      buf0_reg_q   <= buf0_reg_d;
      buf0_data_q  <= buf0_data_d;
      buf1_full_q  <= buf1_full_d;
      buf1_reg_q   <= buf1_reg_d;
      buf1_data_q  <= buf1_data_d;
      old0_q       <= old0_d;
      tie_q        <= tie_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      gid_q        <= gid_d;
    end
  end

  always_comb begin
    pending = '0;
    if (buf0_full_q) pending[buf0_reg_q] = 1'b1;
    if (buf1_full_q) pending[buf1_reg_q] = 1'b1;
    if (we_q)        pending[wreg_q]     = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus.req0_ready       = ready0;
  assign bus.req1_ready       = ready1;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.grant_id         = gid_q;
  assign bus.pending_mask     = pending;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic ctrl_reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();
  regfile_write_arbiter dut (.clock(clock), .ctrl_reset(ctrl_reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffers tagged with the edge number at which they were accepted.
  bit          m_full[2];
  logic [4:0]  m_reg[2];
  logic [31:0] m_data[2];
  int          m_seq[2];
  int          m_last;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_gid;
  int          m_edge = 0;
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_seq[0] < m_seq[1]) return 0;
      if (m_seq[1] < m_seq[0]) return 1;
      return (m_last == 1) ? 0 : 1;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = 32'd0;
    if (m_full[0]) p[m_reg[0]] = 1'b1;
    if (m_full[1]) p[m_reg[1]] = 1'b1;
    if (m_we)      p[m_wreg]   = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic m_ready(int n);
    return ctrl_reset && (!m_full[n] || m_grant() == n);
  endfunction

  task automatic model_edge();
    int g;
    bit rd[2];
    bit v[2];
    logic [4:0] r[2];
    logic [31:0] d[2];
    v[0] = bus.req0_valid; r[0] = bus.req0_reg; d[0] = bus.req0_data;
    v[1] = bus.req1_valid; r[1] = bus.req1_reg; d[1] = bus.req1_data;
    if (!ctrl_reset) begin
      m_full[0] = 0; m_full[1] = 0;
      m_last = 1; m_we = 0; m_wreg = 0; m_wdata = 0; m_gid = 0;
    end else begin
      if (m_we) m_rf[m_wreg] = m_wdata;
      g = m_grant();
      rd[0] = m_ready(0);
      rd[1] = m_ready(1);
      if (g >= 0) begin
        m_we = 1; m_wreg = m_reg[g]; m_wdata = m_data[g];
        m_gid = g; m_last = g; m_full[g] = 0;
      end else begin
        m_we = 0;
      end
      for (int n = 0; n < 2; n++) begin
        if (v[n] && rd[n] && r[n] != 5'd0) begin
          m_full[n] = 1; m_reg[n] = r[n]; m_data[n] = d[n]; m_seq[n] = m_edge;
        end
      end
    end
    m_edge++;
  endtask

  task automatic tick();
    logic pre_we, pre_rst;
    logic [4:0] pre_reg;
    logic [31:0] pre_data;
    pre_we = bus.ctrl_writeEnable; pre_reg = bus.ctrl_writeReg;
    pre_data = bus.data_writeReg;  pre_rst = ctrl_reset;
    @(posedge clock);
    if (pre_rst === 1'b1 && pre_we === 1'b1) d_rf[pre_reg] = pre_data;
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b expected 0", bus.ctrl_writeEnable); end
    n_vec++; if (bus.ctrl_writeReg !== 5'd0) begin n_err++; $display("FAIL rst_wreg: got %0d expected 0", bus.ctrl_writeReg); end
    n_vec++; if (bus.data_writeReg !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h expected 0", bus.data_writeReg); end
    n_vec++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL rst_gid: got %b expected 0", bus.grant_id); end
    n_vec++; if (bus.pending_mask !== 32'd0) begin n_err++; $display("FAIL rst_pending: got %h expected 0", bus.pending_mask); end
    n_vec++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0: got %b expected 0", bus.req0_ready); end
    n_vec++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1: got %b expected 0", bus.req1_ready); end
    ctrl_reset = 1'b1;
    #1;
    n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready0: got %b expected 1", bus.req0_ready); end
    n_vec++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready1: got %b expected 1", bus.req1_ready); end
    tick();
    n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL idle_we: got %b expected 0", bus.ctrl_writeEnable); end
    n_vec++; if (bus.pending_mask !== 32'd0) begin n_err++; $display("FAIL idle_pending: got %h expected 0", bus.pending_mask); end
  endtask

  task automatic test_single_write();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    #1;
    n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready: got %b expected 1", bus.req0_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (bus.pending_mask !== 32'h20) begin n_err++; $display("FAIL sw_pend_e: got %h expected 20", bus.pending_mask); end
    n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL sw_we_e: got %b expected 0", bus.ctrl_writeEnable); end
    tick();
    n_vec++; if (bus.ctrl_writeEnable !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b expected 1", bus.ctrl_writeEnable); end
    n_vec++; if (bus.ctrl_writeReg !== 5'd5) begin n_err++; $display("FAIL sw_wreg: got %0d expected 5", bus.ctrl_writeReg); end
    n_vec++; if (bus.data_writeReg !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata: got %h expected deadbeef", bus.data_writeReg); end
    n_vec++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL sw_gid: got %b expected 0", bus.grant_id); end
    n_vec++; if (bus.pending_mask !== 32'h20) begin n_err++; $display("FAIL sw_pend_e1: got %h expected 20", bus.pending_mask); end
    tick();
    n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL sw_we_end: got %b expected 0", bus.ctrl_writeEnable); end
    n_vec++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL sw_pend_end: got %h expected 0", bus.pending_mask); end
  endtask

  task automatic test_same_edge_tie();
    ctrl_reset = 1'b0;
    tick();
    ctrl_reset = 1'b1;
    drive(1, 3, 32'h11, 1, 4, 32'h22);
    #1;
    n_vec++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin n_err++; $display("FAIL tie_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (bus.pending_mask !== 32'h18) begin n_err++; $display("FAIL tie_pend0: got %h expected 18", bus.pending_mask); end
    tick();
    n_vec++; if ({bus.ctrl_writeEnable, bus.grant_id, bus.ctrl_writeReg} !== {1'b1, 1'b0, 5'd3}) begin n_err++; $display("FAIL tie_first: got we=%b gid=%b reg=%0d expected we=1 gid=0 reg=3", bus.ctrl_writeEnable, bus.grant_id, bus.ctrl_writeReg); end
    n_vec++; if (bus.data_writeReg !== 32'h11) begin n_err++; $display("FAIL tie_data0: got %h expected 11", bus.data_writeReg); end
    n_vec++; if (bus.pending_mask !== 32'h18) begin n_err++; $display("FAIL tie_pend1: got %h expected 18", bus.pending_mask); end
    tick();
    n_vec++; if ({bus.ctrl_writeEnable, bus.grant_id, bus.ctrl_writeReg} !== {1'b1, 1'b1, 5'd4}) begin n_err++; $display("FAIL tie_second: got we=%b gid=%b reg=%0d expected we=1 gid=1 reg=4", bus.ctrl_writeEnable, bus.grant_id, bus.ctrl_writeReg); end
    n_vec++; if (bus.data_writeReg !== 32'h22) begin n_err++; $display("FAIL tie_data1: got %h expected 22", bus.data_writeReg); end
    n_vec++; if (bus.pending_mask !== 32'h10) begin n_err++; $display("FAIL tie_pend2: got %h expected 10", bus.pending_mask); end
    tick();
    n_vec++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL tie_pend3: got %h expected 0", bus.pending_mask); end
  endtask

  task automatic test_ordering();
    drive(0, 0, 0, 1, 7, 32'hA);
    tick();
    drive(1, 7, 32'hB, 0, 0, 0);
    #1;
    n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL ord_ready0: got %b expected 1", bus.req0_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if ({bus.ctrl_writeEnable, bus.grant_id, bus.data_writeReg} !== {1'b1, 1'b1, 32'hA}) begin n_err++; $display("FAIL ord_first: got we=%b gid=%b data=%h expected we=1 gid=1 data=a", bus.ctrl_writeEnable, bus.grant_id, bus.data_writeReg); end
    tick();
    n_vec++; if ({bus.ctrl_writeEnable, bus.grant_id, bus.data_writeReg} !== {1'b1, 1'b0, 32'hB}) begin n_err++; $display("FAIL ord_second: got we=%b gid=%b data=%h expected we=1 gid=0 data=b", bus.ctrl_writeEnable, bus.grant_id, bus.data_writeReg); end
    tick();
    tick();
    n_vec++; if (d_rf[7] !== 32'hB) begin n_err++; $display("FAIL ord_final: got %h expected b", d_rf[7]); end
  endtask

  task automatic test_reg0_discard();
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    #1;
    n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %b expected 1", bus.req0_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL r0_pend: got %h expected 0", bus.pending_mask); end
    tick();
    n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL r0_we: got %b expected 0", bus.ctrl_writeEnable); end
    n_vec++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL r0_pend2: got %h expected 0", bus.pending_mask); end
  endtask

  task automatic test_reset_mid();
    drive(1, 20, 32'h2020, 1, 21, 32'h2121);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (bus.pending_mask !== 32'h0030_0000) begin n_err++; $display("FAIL rm_full: got %h expected 00300000", bus.pending_mask); end
    ctrl_reset = 1'b0;
    tick();
    ctrl_reset = 1'b1;
    #1;
    n_vec++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL rm_pend: got %h expected 0", bus.pending_mask); end
    n_vec++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin n_err++; $display("FAIL rm_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.ctrl_writeEnable !== 1'b0) begin n_err++; $display("FAIL rm_we%0d: got %b expected 0", i, bus.ctrl_writeEnable); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ctrl_reset = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 7) == 0) bus.req1_reg = 5'($urandom_range(0, 31));
      #1;
      n_vec++; if (bus.req0_ready !== m_ready(0)) begin n_err++; $display("FAIL rnd_ready0 @%0d: got %b expected %b", i, bus.req0_ready, m_ready(0)); end
      n_vec++; if (bus.req1_ready !== m_ready(1)) begin n_err++; $display("FAIL rnd_ready1 @%0d: got %b expected %b", i, bus.req1_ready, m_ready(1)); end
      n_vec++; if (bus.pending_mask !== m_pending()) begin n_err++; $display("FAIL rnd_pending @%0d: got %h expected %h", i, bus.pending_mask, m_pending()); end
      tick();
      n_vec++; if (bus.ctrl_writeEnable !== m_we) begin n_err++; $display("FAIL rnd_we @%0d: got %b expected %b", i, bus.ctrl_writeEnable, m_we); end
      if (m_we) begin
        n_vec++;
        if (bus.ctrl_writeReg !== m_wreg || bus.data_writeReg !== m_wdata || bus.grant_id !== 1'(m_gid)) begin
          n_err++;
          $display("FAIL rnd_port @%0d: got reg=%0d data=%h gid=%b expected reg=%0d data=%h gid=%0d",
                   i, bus.ctrl_writeReg, bus.data_writeReg, bus.grant_id, m_wreg, m_wdata, m_gid);
        end
      end
    end
    ctrl_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    for (int r = 1; r < 32; r++) begin
      n_vec++; if (d_rf[r] !== m_rf[r]) begin n_err++; $display("FAIL rnd_rf[%0d]: got %h expected %h", r, d_rf[r], m_rf[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = 32'd0;
      d_rf[r] = 32'd0;
    end
    m_full[0] = 0; m_full[1] = 0; m_last = 1; m_we = 0;
    ctrl_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_write();
    test_same_edge_tie();
    test_ordering();
    test_reg0_discard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
